// File: rtl/seq_mul_if.sv
// seq_mul_if: start/busy/done handshake and operand/product bus for seq_mul
interface seq_mul_if #(parameter int WIDTH = 8);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;
    modport master (output start, a, b, input busy, done, p);
    modport slave (input start, a, b, output busy, done, p);
endinterface

// File: rtl/seq_mul.sv
// seq_mul: multi-cycle unsigned shift-and-add multiplier, one add+shift per cycle
module seq_mul #(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    seq_mul_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, p_q, p_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     sum;

    // Upper half plus multiplicand keeps its carry so it can shift into the MSB
    assign sum = acc_q[0] ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q}
                          : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        p_d     = p_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        if (state_q == RUN) begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                p_d     = {sum, acc_q[WIDTH-1:1]};
                state_d = DONE;
            end
        end else if (bus.start) begin
            mcand_d = bus.a;
            acc_d   = {{WIDTH{1'b0}}, bus.b};
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            p_q     <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.p    = p_q;
endmodule
